// File: rtl/cache_pkg.sv
// Shared L1/L2 request types for the L2 request front end.
// Packet layouts are fixed here and consumed by the arbiter and its FIFOs.
package cache_pkg;

  localparam int CFG_NUM_CORES = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int CORE_ID_W = $clog2(CFG_NUM_CORES);

  typedef enum logic [1:0] {
    READ      = 2'd0,
    READ_EXCL = 2'd1,
    UPGRADE   = 2'd2,
    WRITEBACK = 2'd3
  } cmd_e;

  typedef struct packed {
    cmd_e              cmd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } l1_req_packet_t;

  typedef struct packed {
    logic [CORE_ID_W-1:0] core_id;
    cmd_e                 cmd;
    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    data;
  } l2_entry_packet_t;

endpackage

// File: rtl/l2_req_arbiter_fifo.sv
// Per-core request FIFO; ready depends only on the registered count,
// so a full FIFO refuses a push even in a cycle where it is popped.
module req_fifo
  import cache_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = l1_req_packet_t
) (
  input  logic clock,
  input  logic reset,
  input  logic valid,
  input  logic pop,
  input  T     wdata,
  output logic ready,
  output logic empty,
  output T     head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  T mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;

  assign ready = reset && (count != CW'(DEPTH));
  assign empty = (count == '0);
  assign push  = valid && ready;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/l2_req_arbiter.sv
// Collects L1 miss/writeback requests and feeds the L2 one per cycle
// through a registered valid/ready slot with round-robin core selection.
module l2_req_arbiter
  import cache_pkg::*;
#(
  parameter int NUM_CORES  = CFG_NUM_CORES,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_CORES-1:0]             l1_req_valid,
  input  l1_req_packet_t [NUM_CORES-1:0]   l1_req_packet,
  output logic [NUM_CORES-1:0]             l1_req_ready,
  output logic                             l2_entry_valid,
  output l2_entry_packet_t                 l2_entry_packet,
  input  logic                             l2_entry_ready
);

  localparam logic [CORE_ID_W-1:0] LAST =
    CORE_ID_W'(NUM_CORES - 1);

  logic [NUM_CORES-1:0] empty;
  logic [NUM_CORES-1:0] pop;
  l1_req_packet_t       head [NUM_CORES];

  logic [CORE_ID_W-1:0] rr_ptr;
  logic [CORE_ID_W-1:0] grant_idx;
  logic [CORE_ID_W-1:0] sel;
  logic                 grant_valid;
  logic                 slot_free;
  l1_req_packet_t       grant_pkt;

  assign slot_free = !l2_entry_valid || l2_entry_ready;

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_fifo
    assign pop[i] = slot_free && grant_valid &&
                    (grant_idx == CORE_ID_W'(i));

    req_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (l1_req_packet_t)
    ) u_fifo (
      .clock (clock),
      .reset (reset),
      .valid (l1_req_valid[i]),
      .pop   (pop[i]),
      .wdata (l1_req_packet[i]),
      .ready (l1_req_ready[i]),
      .empty (empty[i]),
      .head  (head[i])
    );
  end

  // Cyclic search from rr_ptr; first non-empty FIFO wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    sel         = rr_ptr;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (!grant_valid && !empty[sel]) begin
        grant_valid = 1'b1;
        grant_idx   = sel;
      end
      sel = (sel == LAST) ? '0 : sel + CORE_ID_W'(1);
    end
  end

  assign grant_pkt = head[grant_idx];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      l2_entry_valid  <= 1'b0;
      l2_entry_packet <= '0;
      rr_ptr          <= '0;
    end else if (slot_free && grant_valid) begin
      l2_entry_valid          <= 1'b1;
      l2_entry_packet.core_id <= grant_idx;
      l2_entry_packet.cmd     <= grant_pkt.cmd;
      l2_entry_packet.addr    <= grant_pkt.addr;
      l2_entry_packet.data    <= grant_pkt.data;
      rr_ptr <= (grant_idx == LAST) ? '0 : grant_idx + CORE_ID_W'(1);
    end else if (l2_entry_ready) begin
      l2_entry_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Directed bench for l2_req_arbiter: latency, round robin, backpressure,
// full-FIFO push rejection, empty skipping and mid-stream reset.
module tb_l2_req_arbiter;
  import cache_pkg::*;

  localparam int NC = CFG_NUM_CORES;

  logic                    clock = 1'b0;
  logic                    reset = 1'b0;
  logic [NC-1:0]           l1_req_valid;
  l1_req_packet_t [NC-1:0] l1_req_packet;
  logic [NC-1:0]           l1_req_ready;
  logic                    l2_entry_valid;
  l2_entry_packet_t        l2_entry_packet;
  logic                    l2_entry_ready;

  int n_tests = 0;
  int n_fail  = 0;

  l2_req_arbiter #(
    .NUM_CORES  (NC),
    .FIFO_DEPTH (2)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .l1_req_valid    (l1_req_valid),
    .l1_req_packet   (l1_req_packet),
    .l1_req_ready    (l1_req_ready),
    .l2_entry_valid  (l2_entry_valid),
    .l2_entry_packet (l2_entry_packet),
    .l2_entry_ready  (l2_entry_ready)
  );

  always #5 clock = ~clock;

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  function automatic l1_req_packet_t mk(input cmd_e c,
                                        input logic [31:0] a,
                                        input logic [63:0] d);
    l1_req_packet_t p;
    p.cmd  = c;
    p.addr = a;
    p.data = d;
    return p;
  endfunction

  task automatic do_reset();
    l1_req_valid   = '0;
    l1_req_packet  = '0;
    l2_entry_ready = 1'b1;
    reset = 1'b0;
    cyc(2);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    l1_req_valid   = '0;
    l1_req_packet  = '0;
    l2_entry_ready = 1'b1;
    cyc(2);
    n_tests++;
    if (l2_entry_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_valid got=%b exp=0", l2_entry_valid);
    end
    n_tests++;
    if (l2_entry_packet !== '0) begin
      n_fail++;
      $display("FAIL rst_packet got=%h exp=0", l2_entry_packet);
    end
    n_tests++;
    if (l1_req_ready !== 4'h0) begin
      n_fail++;
      $display("FAIL rst_ready got=%b exp=0000", l1_req_ready);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if (l1_req_ready !== 4'hF) begin
      n_fail++;
      $display("FAIL rel_ready got=%b exp=1111", l1_req_ready);
    end
    cyc(1);
  endtask

  task automatic test_single();
    do_reset();
    l1_req_valid     = 4'b0100;
    l1_req_packet[2] = mk(READ, 32'h0000_1040, 64'hA5);
    cyc(1);
    l1_req_valid = '0;
    n_tests++;
    if (l2_entry_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_n1 got=%b exp=0", l2_entry_valid);
    end
    cyc(1);
    n_tests++;
    if (l2_entry_valid !== 1'b1 ||
        l2_entry_packet.core_id !== 2'd2 ||
        l2_entry_packet.addr !== 32'h0000_1040 ||
        l2_entry_packet.cmd !== READ ||
        l2_entry_packet.data !== 64'hA5) begin
      n_fail++;
      $display("FAIL single_n2 got v=%b pkt=%h exp v=1 id=2 a=1040",
               l2_entry_valid, l2_entry_packet);
    end
    cyc(1);
    n_tests++;
    if (l2_entry_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_n3 got=%b exp=0", l2_entry_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_id;
    do_reset();
    for (int i = 0; i < NC; i++)
      l1_req_packet[i] = mk(cmd_e'(i), 32'h100 * i, 64'(i));
    l1_req_valid = 4'hF;
    cyc(1);
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      exp_id = 2'(k % NC);
      n_tests++;
      if (l2_entry_valid !== 1'b1 ||
          l2_entry_packet.core_id !== exp_id ||
          l2_entry_packet.cmd !== cmd_e'(exp_id)) begin
        n_fail++;
        $display("FAIL rr_%0d got v=%b id=%0d exp v=1 id=%0d",
                 k, l2_entry_valid, l2_entry_packet.core_id, exp_id);
      end
    end
    l1_req_valid = '0;
  endtask

  task automatic test_backpressure();
    int hold_bad;
    do_reset();
    l2_entry_ready   = 1'b0;
    l1_req_valid     = 4'b0010;
    l1_req_packet[1] = mk(WRITEBACK, 32'h2000, 64'h10);
    cyc(1);
    l1_req_packet[1] = mk(READ_EXCL, 32'h2010, 64'h11);
    cyc(1);
    l1_req_packet[1] = mk(UPGRADE, 32'h2020, 64'h12);
    cyc(1);
    l1_req_packet[1] = mk(READ, 32'h2030, 64'h13);
    n_tests++;
    if (l1_req_ready[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full got=%b exp=0", l1_req_ready[1]);
    end
    hold_bad = 0;
    for (int k = 0; k < 7; k++) begin
      if (l2_entry_valid !== 1'b1 ||
          l2_entry_packet.addr !== 32'h2000 ||
          l2_entry_packet.core_id !== 2'd1 ||
          l1_req_ready[1] !== 1'b0)
        hold_bad++;
      cyc(1);
    end
    n_tests++;
    if (hold_bad != 0) begin
      n_fail++;
      $display("FAIL bp_hold got=%0d bad cycles exp=0", hold_bad);
    end
    n_tests++;
    if (l2_entry_packet.addr !== 32'h2000 ||
        l2_entry_packet.cmd !== WRITEBACK) begin
      n_fail++;
      $display("FAIL bp_slot got=%h exp a=2000 WB", l2_entry_packet);
    end
    l1_req_valid   = '0;
    l2_entry_ready = 1'b1;
    cyc(1);
    n_tests++;
    if (l2_entry_valid !== 1'b1 ||
        l2_entry_packet.addr !== 32'h2010) begin
      n_fail++;
      $display("FAIL bp_drain1 got v=%b a=%h exp v=1 a=2010",
               l2_entry_valid, l2_entry_packet.addr);
    end
    cyc(1);
    n_tests++;
    if (l2_entry_valid !== 1'b1 ||
        l2_entry_packet.addr !== 32'h2020) begin
      n_fail++;
      $display("FAIL bp_drain2 got v=%b a=%h exp v=1 a=2020",
               l2_entry_valid, l2_entry_packet.addr);
    end
    cyc(1);
    n_tests++;
    if (l2_entry_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_empty got=%b exp=0", l2_entry_valid);
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    l2_entry_ready   = 1'b0;
    l1_req_valid     = 4'b0001;
    l1_req_packet[0] = mk(READ, 32'h3000, 64'h20);
    cyc(1);
    l1_req_packet[0] = mk(READ, 32'h3010, 64'h21);
    cyc(1);
    l1_req_packet[0] = mk(READ, 32'h3020, 64'h22);
    cyc(1);
    l1_req_packet[0] = mk(READ, 32'h3030, 64'h23);
    l2_entry_ready   = 1'b1;
    n_tests++;
    if (l1_req_ready[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL fp_reject got=%b exp=0", l1_req_ready[0]);
    end
    cyc(1);
    l2_entry_ready = 1'b0;
    n_tests++;
    if (l2_entry_packet.addr !== 32'h3010 ||
        l1_req_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL fp_pop got a=%h rdy=%b exp a=3010 rdy=1",
               l2_entry_packet.addr, l1_req_ready[0]);
    end
    cyc(1);
    l1_req_valid = '0;
    n_tests++;
    if (l1_req_ready[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL fp_refull got=%b exp=0", l1_req_ready[0]);
    end
    l2_entry_ready = 1'b1;
    cyc(1);
    n_tests++;
    if (l2_entry_packet.addr !== 32'h3020) begin
      n_fail++;
      $display("FAIL fp_d1 got=%h exp=3020", l2_entry_packet.addr);
    end
    cyc(1);
    n_tests++;
    if (l2_entry_valid !== 1'b1 ||
        l2_entry_packet.addr !== 32'h3030) begin
      n_fail++;
      $display("FAIL fp_d2 got v=%b a=%h exp v=1 a=3030",
               l2_entry_valid, l2_entry_packet.addr);
    end
    cyc(1);
    n_tests++;
    if (l2_entry_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fp_end got=%b exp=0", l2_entry_valid);
    end
  endtask

  task automatic test_skip_empty();
    logic [1:0] exp_seq [4];
    exp_seq = '{2'd3, 2'd1, 2'd3, 2'd1};
    do_reset();
    l1_req_valid     = 4'b0010;
    l1_req_packet[1] = mk(READ, 32'h4100, 64'h1);
    cyc(1);
    l1_req_valid = '0;
    cyc(2);
    l1_req_packet[3] = mk(WRITEBACK, 32'h4300, 64'h3);
    l1_req_valid     = 4'b1010;
    cyc(1);
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      n_tests++;
      if (l2_entry_valid !== 1'b1 ||
          l2_entry_packet.core_id !== exp_seq[k]) begin
        n_fail++;
        $display("FAIL skip_%0d got v=%b id=%0d exp v=1 id=%0d",
                 k, l2_entry_valid, l2_entry_packet.core_id,
                 exp_seq[k]);
      end
    end
    l1_req_valid = '0;
  endtask

  task automatic test_mid_reset();
    int stale;
    do_reset();
    l2_entry_ready = 1'b0;
    for (int i = 0; i < NC; i++)
      l1_req_packet[i] = mk(READ, 32'h5000 + 32'(i), 64'(i));
    l1_req_valid = 4'hF;
    cyc(1);
    l1_req_valid = 4'b0110;
    cyc(1);
    l1_req_valid = '0;
    n_tests++;
    if (l2_entry_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mr_pre got=%b exp=1", l2_entry_valid);
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (l2_entry_valid !== 1'b0 || l1_req_ready !== 4'h0) begin
      n_fail++;
      $display("FAIL mr_async got v=%b rdy=%b exp v=0 rdy=0000",
               l2_entry_valid, l1_req_ready);
    end
    l2_entry_ready = 1'b1;
    cyc(1);
    reset = 1'b1;
    #1;
    n_tests++;
    if (l1_req_ready !== 4'hF) begin
      n_fail++;
      $display("FAIL mr_ready got=%b exp=1111", l1_req_ready);
    end
    stale = 0;
    for (int k = 0; k < 6; k++) begin
      cyc(1);
      if (l2_entry_valid !== 1'b0) stale++;
    end
    n_tests++;
    if (stale != 0) begin
      n_fail++;
      $display("FAIL mr_stale got=%0d valid cycles exp=0", stale);
    end
  endtask

  initial begin
    l1_req_valid   = '0;
    l1_req_packet  = '0;
    l2_entry_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_full_pop();
    test_skip_empty();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
